bcd_a_binario: RTL and testbench

BCD_A_BINARIO -- requirements
Module: bcd_a_binario

---
 rtl/booth_pkg.sv | 17 +
 rtl/mult10_suma.sv | 15 +
 rtl/bcd_a_binario.sv | 117 +++++++++++
 tb/tb_bcd_a_binario.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and defaults for the signed-BCD to two's-complement converter.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACUMULA = 2'd1,
        SIGNO   = 2'd2,
        LISTO   = 2'd3
    } estado_t;

    localparam int N_DIGITOS_DEF = 5;
    localparam int ANCHO_RES_DEF = 18;

    // Sign bit value meaning "non-negative"; 0 means negative.
    localparam logic SIGNO_NO_NEG = 1'b1;

endpackage

// File: rtl/mult10_suma.sv
// Combinational acc*10 + digit step, truncated to ANCHO bits.
// Latency: none (pure combinational).
// Backpressure: none; the caller decides when to register the sum.
module mult10_suma #(
    parameter int ANCHO = 18
) (
    input  logic [ANCHO-1:0] acc,
    input  logic [3:0]       digito,
    output logic [ANCHO-1:0] suma
);

    // Shift-add times ten; wrap-around is intentional for widths that overflow.
    assign suma = (acc << 3) + (acc << 1) + {{(ANCHO-4){1'b0}}, digito};

endmodule

// File: rtl/bcd_a_binario.sv
// Serial signed-BCD to two's-complement converter, most significant digit first.
// Latency: listo pulses N_DIGITOS+1 edges after the edge that samples inicio.
// Backpressure: none; inicio is ignored while busy or while listo is shown.
module bcd_a_binario
    import booth_pkg::*;
#(
    parameter int N_DIGITOS = N_DIGITOS_DEF,
    parameter int ANCHO_RES = ANCHO_RES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*N_DIGITOS:0]   codigo_BCD,
    input  logic                   inicio,
    output logic                   ocupado,
    output logic                   listo,
    output logic [ANCHO_RES-1:0]   resultado,
    output logic                   error
);

    localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [IDX_W-1:0] IDX_INI = IDX_W'(N_DIGITOS - 1);

    estado_t                estado, estado_sig;
    logic [4*N_DIGITOS:0]   captura;
    logic [ANCHO_RES-1:0]   acc;
    logic [ANCHO_RES-1:0]   acc_sig;
    logic [IDX_W-1:0]       idx;
    logic                   invalido;
    logic [3:0]             digito;
    logic                   carga, acumula, fija;

    assign digito = captura[{idx, 2'b00} +: 4];

    mult10_suma #(.ANCHO(ANCHO_RES)) u_mult10_suma (
        .acc    (acc),
        .digito (digito),
        .suma   (acc_sig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        carga      = 1'b0;
        acumula    = 1'b0;
        fija       = 1'b0;
        ocupado    = 1'b0;
        listo      = 1'b0;
        case (estado)
            IDLE: begin
                if (inicio) begin
                    carga      = 1'b1;
                    estado_sig = ACUMULA;
                end
            end
            ACUMULA: begin
                ocupado = 1'b1;
                acumula = 1'b1;
                if (idx == '0) begin
                    estado_sig = SIGNO;
                end
            end
            SIGNO: begin
                ocupado    = 1'b1;
                fija       = 1'b1;
                estado_sig = LISTO;
            end
            LISTO: begin
                listo      = 1'b1;
                estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captura   <= '0;
            acc       <= '0;
            idx       <= '0;
            invalido  <= 1'b0;
            resultado <= '0;
            error     <= 1'b0;
        end else begin
            if (carga) begin
                captura  <= codigo_BCD;
                acc      <= '0;
                idx      <= IDX_INI;
                invalido <= 1'b0;
            end
            if (acumula) begin
                acc <= acc_sig;
                idx <= idx - 1'b1;
                // Bad digits still feed the accumulator; only the flag matters.
                if (digito > 4'd9) begin
                    invalido <= 1'b1;
                end
            end
            if (fija) begin
                if (invalido) begin
                    resultado <= '0;
                    error     <= 1'b1;
                end else begin
                    resultado <= (captura[4*N_DIGITOS] == SIGNO_NO_NEG) ? acc : -acc;
                    error     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_a_binario.sv
// Scoreboarded bench: directed cases plus random codes against an arithmetic reference.
module tb_bcd_a_binario;

    logic        clk;
    logic        rst_n;
    logic [20:0] codigo;
    logic        inicio;
    logic        ocupado;
    logic        listo;
    logic [17:0] resultado;
    logic        error;

    int checks = 0;
    int errors = 0;
    int ciclo  = 0;

    typedef struct {
        logic [17:0] res;
        logic        err;
        int          cyc;
    } esperado_t;

    esperado_t cola[$];

    bcd_a_binario dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .codigo_BCD (codigo),
        .inicio     (inicio),
        .ocupado    (ocupado),
        .listo      (listo),
        .resultado  (resultado),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] req);
        checks++;
        if (actual !== req) begin
            errors++;
            $display("FAIL %s actual=%0h esperado=%0h (ciclo %0d)", nombre, actual, req, ciclo);
        end
    endtask

    // Reference: value = sum of digit*10^k, negated for sign 0, zero with error on any bad digit.
    function automatic void modelo(input logic [20:0] c, output logic [17:0] r, output logic e);
        int v;
        logic [3:0] d;
        v = 0;
        e = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            d = c[4*k +: 4];
            if (d > 4'd9) e = 1'b1;
            v = v * 10 + int'(d);
        end
        if (e)          r = 18'd0;
        else if (c[20]) r = 18'(v);
        else            r = 18'(-v);
    endfunction

    // Monitor: every listo pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && listo) begin
            if (cola.size() == 0) begin
                chk("listo_inesperado", 32'd1, 32'd0);
            end else begin
                esperado_t x;
                x = cola.pop_front();
                chk("resultado", 32'(resultado), 32'(x.res));
                chk("error", 32'(error), 32'(x.err));
                chk("latencia_listo", 32'(ciclo), 32'(x.cyc));
            end
        end
    end

    task automatic lanzar(input logic [20:0] c, input logic [17:0] r, input logic e);
        @(negedge clk);
        codigo = c;
        inicio = 1'b1;
        cola.push_back('{r, e, ciclo + 7});
        @(negedge clk);
        inicio = 1'b0;
        repeat (7) @(negedge clk);
        chk("mantiene_resultado", 32'(resultado), 32'(r));
        chk("mantiene_error", 32'(error), 32'(e));
    endtask

    initial begin
        logic [20:0] c;
        logic [17:0] r;
        logic        e;
        int          k0;

        rst_n  = 1'b1;
        codigo = '0;
        inicio = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_resultado", 32'(resultado), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        lanzar(21'h112345, 18'h03039, 1'b0);
        lanzar(21'h012345, 18'h3CFC7, 1'b0);
        lanzar(21'h099999, 18'h27961, 1'b0);
        lanzar(21'h1123A5, 18'h00000, 1'b1);
        lanzar(21'h000000, 18'h00000, 1'b0);

        // Input changes and a re-pulsed inicio during accumulation must be ignored.
        @(negedge clk);
        k0 = ciclo;
        codigo = 21'h112345;
        inicio = 1'b1;
        cola.push_back('{18'h03039, 1'b0, k0 + 7});
        @(negedge clk);
        inicio = 1'b0;
        chk("ocupado_1", 32'(ocupado), 32'd1);
        @(negedge clk);
        codigo = 21'h100001;
        inicio = 1'b1;
        chk("ocupado_2", 32'(ocupado), 32'd1);
        @(negedge clk);
        inicio = 1'b0;
        for (int i = 3; i <= 6; i++) begin
            chk("ocupado_acumula", 32'(ocupado), 32'd1);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("una_sola_conversion", 32'(cola.size()), 32'd0);

        // inicio held high: second conversion starts at the first edge back in IDLE.
        @(negedge clk);
        k0 = ciclo;
        codigo = 21'h154321;
        inicio = 1'b1;
        cola.push_back('{18'(54321), 1'b0, k0 + 7});
        cola.push_back('{18'(54321), 1'b0, k0 + 15});
        repeat (9) @(negedge clk);
        inicio = 1'b0;
        repeat (9) @(negedge clk);

        // Reset in the third accumulation cycle aborts with no listo pulse.
        @(negedge clk);
        codigo = 21'h112345;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (2) @(negedge clk);
        chk("ocupado_antes_rst", 32'(ocupado), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        chk("abort_listo", 32'(listo), 32'd0);
        chk("abort_resultado", 32'(resultado), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        k0     = ciclo;
        codigo = 21'h100007;
        inicio = 1'b1;
        cola.push_back('{18'd7, 1'b0, k0 + 7});
        @(negedge clk);
        inicio = 1'b0;
        repeat (7) @(negedge clk);
        chk("post_rst_resultado", 32'(resultado), 32'd7);

        for (int n = 0; n < 24; n++) begin
            c[20] = 1'($urandom_range(0, 1));
            for (int k = 0; k < 5; k++) begin
                c[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
            end
            modelo(c, r, e);
            lanzar(c, r, e);
        end

        repeat (4) @(negedge clk);
        chk("cola_vacia", 32'(cola.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d esperado=fin", ciclo);
        $fatal(1, "timeout");
    end

endmodule
